// File: rtl/clos_router_node.sv
// One Clos TCDM switching stage: per-output round-robin crossbar plus a delayed response return path.
// Request path is combinational (zero latency, gnt_o follows gnt_i); responses return MemLatency cycles after grant.
module clos_router_node #(
  parameter int NumIn         = 4,
  parameter int NumOut        = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter bit WriteRespOn   = 1'b1,
  parameter int MemLatency    = 1,
  parameter int NodeType      = 0,
  localparam int AW           = (NumOut > 1) ? $clog2(NumOut) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0][AW-1:0]               add_i,
  input  logic [NumIn-1:0]                       wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]     wdata_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]    rdata_o,
  input  logic [NumOut-1:0]                      gnt_i,
  output logic [NumOut-1:0]                      req_o,
  output logic [NumOut-1:0][ReqDataWidth-1:0]    wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]   rdata_i
);

  localparam int IW = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [AW-1:0]                  ptr_q;
  logic [NumIn-1:0][AW-1:0]       dest;
  logic [NumOut-1:0][IW-1:0]      rr_q;
  logic [NumOut-1:0][IW-1:0]      win;
  logic [NumOut-1:0]              any;
  logic [IW-1:0]                  idx;

  logic [MemLatency-1:0][NumIn-1:0]         sr_vld;
  logic [MemLatency-1:0][NumIn-1:0]         sr_wen;
  logic [MemLatency-1:0][NumIn-1:0][AW-1:0] sr_port;

  // Ingress mode spreads inputs over disjoint outputs with a rotating offset, so it ignores add_i.
  always_comb begin
    dest = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (NumOut == 1)
        dest[i] = '0;
      else if (NodeType == 1)
        dest[i] = add_i[i];
      else
        dest[i] = AW'(i * (NumOut / NumIn)) + ptr_q;
    end
  end

  always_comb begin
    any = '0;
    win = '0;
    idx = '0;
    for (int j = 0; j < NumOut; j++) begin
      for (int k = 0; k < NumIn; k++) begin
        idx = rr_q[j] + IW'(k);
        if (!any[j] && req_i[idx] && dest[idx] == AW'(j)) begin
          any[j] = 1'b1;
          win[j] = idx;
        end
      end
    end
  end

  always_comb begin
    req_o   = any;
    wdata_o = '0;
    gnt_o   = '0;
    for (int j = 0; j < NumOut; j++)
      if (any[j]) wdata_o[j] = wdata_i[win[j]];
    for (int i = 0; i < NumIn; i++)
      gnt_o[i] = req_i[i] && any[dest[i]] && (win[dest[i]] == IW'(i)) && gnt_i[dest[i]];
  end

  // Priority only moves past the winner once the target has actually accepted it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      rr_q  <= '0;
    end else begin
      ptr_q <= (NumOut > 1) ? ptr_q + AW'(1) : '0;
      for (int j = 0; j < NumOut; j++)
        if (any[j] && gnt_i[j])
          rr_q[j] <= (NumIn > 1) ? win[j] + IW'(1) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_vld  <= '0;
      sr_wen  <= '0;
      sr_port <= '0;
    end else begin
      sr_vld[0]  <= gnt_o;
      sr_wen[0]  <= wen_i;
      sr_port[0] <= dest;
      for (int s = 1; s < MemLatency; s++) begin
        sr_vld[s]  <= sr_vld[s-1];
        sr_wen[s]  <= sr_wen[s-1];
        sr_port[s] <= sr_port[s-1];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    vld_o   = '0;
    for (int i = 0; i < NumIn; i++) begin
      rdata_o[i] = rdata_i[sr_port[MemLatency-1][i]];
      vld_o[i]   = sr_vld[MemLatency-1][i] && (WriteRespOn || !sr_wen[MemLatency-1][i]);
    end
  end

endmodule

// File: tb/tb_clos_router_node.sv
// Bench for clos_router_node: three addressed 4x4 instances (differing response options) share stimulus,
// plus one 2x4 ingress-spreading instance; all outputs are compared against a cycle-level reference model.
module tb_clos_router_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       req, wen, gnt_t;
  logic [3:0][1:0]  add;
  logic [3:0][31:0] wdata, rdata_t;
  logic [1:0]       c_req, c_wen;
  logic [1:0][1:0]  c_add;
  logic [1:0][31:0] c_wdata;

  logic [3:0]       a_gnt, a_vld, a_req_o, b_gnt, b_vld, b_req_o, d_gnt, d_vld, d_req_o;
  logic [3:0][31:0] a_rdata, a_wdata_o, b_rdata, b_wdata_o, d_rdata, d_wdata_o;
  logic [1:0]       c_gnt, c_vld;
  logic [1:0][31:0] c_rdata;
  logic [3:0]       c_req_o;
  logic [3:0][31:0] c_wdata_o;

  clos_router_node #(.NumIn(4), .NumOut(4), .WriteRespOn(1'b1), .MemLatency(1), .NodeType(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(a_gnt), .vld_o(a_vld), .rdata_o(a_rdata), .gnt_i(gnt_t), .req_o(a_req_o),
    .wdata_o(a_wdata_o), .rdata_i(rdata_t));

  clos_router_node #(.NumIn(4), .NumOut(4), .WriteRespOn(1'b0), .MemLatency(1), .NodeType(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(b_gnt), .vld_o(b_vld), .rdata_o(b_rdata), .gnt_i(gnt_t), .req_o(b_req_o),
    .wdata_o(b_wdata_o), .rdata_i(rdata_t));

  clos_router_node #(.NumIn(4), .NumOut(4), .WriteRespOn(1'b1), .MemLatency(2), .NodeType(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(d_gnt), .vld_o(d_vld), .rdata_o(d_rdata), .gnt_i(gnt_t), .req_o(d_req_o),
    .wdata_o(d_wdata_o), .rdata_i(rdata_t));

  clos_router_node #(.NumIn(2), .NumOut(4), .WriteRespOn(1'b1), .MemLatency(1), .NodeType(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .add_i(c_add), .wen_i(c_wen), .wdata_i(c_wdata),
    .gnt_o(c_gnt), .vld_o(c_vld), .rdata_o(c_rdata), .gnt_i(gnt_t), .req_o(c_req_o),
    .wdata_o(c_wdata_o), .rdata_i(rdata_t));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference state: next-priority input per output, spreading offset, and a per-cycle grant log.
  int              rr[4];
  int              cptr;
  logic [3:0]      h_gnt[1024];
  logic [3:0]      h_wen[1024];
  logic [3:0][1:0] h_dest[1024];
  logic [1:0]      hc_gnt[1024];
  logic [1:0][1:0] hc_dest[1024];

  task automatic resp_check(input string tag, input logic [3:0][31:0] obs, input logic [3:0] slot,
                            input logic [3:0][1:0] port);
    logic [127:0] er, mk;
    er = '0;
    mk = '0;
    for (int i = 0; i < 4; i++)
      if (slot[i]) begin
        er[i*32 +: 32] = rdata_t[port[i]];
        mk[i*32 +: 32] = '1;
      end
    if (mk != '0) check(tag, obs & mk, er);
  endtask

  task automatic model_cycle();
    int win[4];
    int cdest[2];
    logic [3:0] e_req, e_gnt, p1, p2, w1, e_creq;
    logic [1:0] e_cgnt, pc;
    logic [127:0] e_wd, e_cwd;
    logic [127:0] cer, cmk;
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) rr[j] = 0;
      cptr = 0;
      for (int t = 0; t <= cyc && t < 1024; t++) begin
        h_gnt[t]  = '0;
        hc_gnt[t] = '0;
      end
    end
    e_req = '0; e_gnt = '0; e_wd = '0;
    for (int j = 0; j < 4; j++) begin
      win[j] = -1;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (rr[j] + k) % 4;
        if (win[j] < 0 && req[i] && add[i] == j) win[j] = i;
      end
      if (win[j] >= 0) begin
        e_req[j] = 1'b1;
        e_wd[j*32 +: 32] = wdata[win[j]];
      end
    end
    for (int i = 0; i < 4; i++)
      e_gnt[i] = req[i] && win[add[i]] == i && gnt_t[add[i]];
    check("a_gnt", a_gnt, e_gnt);
    check("b_gnt", b_gnt, e_gnt);
    check("d_gnt", d_gnt, e_gnt);
    check("a_req_o", a_req_o, e_req);
    check("a_wdata_o", a_wdata_o, e_wd);
    p1 = (cyc >= 1) ? h_gnt[cyc-1] : 4'b0;
    w1 = (cyc >= 1) ? h_wen[cyc-1] : 4'b0;
    p2 = (cyc >= 2) ? h_gnt[cyc-2] : 4'b0;
    check("a_vld", a_vld, p1);
    check("b_vld", b_vld, p1 & ~w1);
    check("d_vld", d_vld, p2);
    if (cyc >= 1) begin
      resp_check("a_rdata", a_rdata, p1, h_dest[cyc-1]);
      resp_check("b_rdata", b_rdata, p1, h_dest[cyc-1]);
    end
    if (cyc >= 2) resp_check("d_rdata", d_rdata, p2, h_dest[cyc-2]);
    h_gnt[cyc]  = rst_n ? e_gnt : 4'b0;
    h_wen[cyc]  = wen;
    h_dest[cyc] = add;
    if (rst_n)
      for (int j = 0; j < 4; j++)
        if (win[j] >= 0 && gnt_t[j]) rr[j] = (win[j] + 1) % 4;

    e_creq = '0; e_cgnt = '0; e_cwd = '0;
    for (int i = 0; i < 2; i++) begin
      cdest[i] = (i * 2 + cptr) % 4;
      if (c_req[i]) begin
        e_creq[cdest[i]] = 1'b1;
        e_cwd[cdest[i]*32 +: 32] = c_wdata[i];
        e_cgnt[i] = gnt_t[cdest[i]];
      end
    end
    check("c_gnt", c_gnt, e_cgnt);
    check("c_req_o", c_req_o, e_creq);
    check("c_wdata_o", c_wdata_o, e_cwd);
    pc = (cyc >= 1) ? hc_gnt[cyc-1] : 2'b0;
    check("c_vld", c_vld, pc);
    cer = '0; cmk = '0;
    for (int i = 0; i < 2; i++)
      if (pc[i]) begin
        cer[i*32 +: 32] = rdata_t[hc_dest[cyc-1][i]];
        cmk[i*32 +: 32] = '1;
      end
    if (cmk != '0) check("c_rdata", {64'b0, c_rdata} & cmk, cer);
    hc_gnt[cyc] = rst_n ? e_cgnt : 2'b0;
    for (int i = 0; i < 2; i++) hc_dest[cyc][i] = 2'(cdest[i]);
    cptr = rst_n ? (cptr + 1) % 4 : 0;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) rdata_t[k] = $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      model_cycle();
      tick();
    end
  endtask

  initial begin
    logic [3:0] onehot;
    rst_n = 1'b0; req = '0; add = '0; wen = '0; wdata = '0; gnt_t = 4'hF;
    c_req = '0; c_wen = '0; c_add = '0; c_wdata = '0;
    for (int k = 0; k < 4; k++) rdata_t[k] = $urandom;
    for (int j = 0; j < 4; j++) rr[j] = 0;
    cptr = 0;
    for (int t = 0; t < 1024; t++) begin
      h_gnt[t] = '0; h_wen[t] = '0; h_dest[t] = '0; hc_gnt[t] = '0; hc_dest[t] = '0;
    end

    @(negedge clk);
    check("rst_a_vld", a_vld, 4'b0);
    check("rst_c_vld", c_vld, 2'b0);
    model_cycle();
    tick();
    run(1);
    rst_n = 1'b1;
    run(1);

    // All four inputs to distinct ports.
    req = 4'hF; wen = '0;
    for (int i = 0; i < 4; i++) begin add[i] = 2'(i); wdata[i] = $urandom; end
    @(negedge clk);
    check("t1_gnt", a_gnt, 4'hF);
    check("t1_req_o", a_req_o, 4'hF);
    check("t1_wdata_o", a_wdata_o, wdata);
    model_cycle(); tick();
    req = '0;
    @(negedge clk);
    check("t1_vld", a_vld, 4'hF);
    check("t1_rdata", a_rdata, rdata_t);
    check("t1_d_vld_early", d_vld, 4'h0);
    model_cycle(); tick();
    @(negedge clk);
    check("t1_d_vld", d_vld, 4'hF);
    model_cycle(); tick();

    // Three inputs contend for port 2.
    req = 4'b0111;
    for (int i = 0; i < 4; i++) add[i] = 2'd2;
    for (int n = 0; n < 3; n++) begin
      onehot = 4'b0001 << n;
      @(negedge clk);
      check("t2_gnt", a_gnt, onehot);
      check("t2_req_o", a_req_o, 4'b0100);
      model_cycle(); tick();
    end

    // Target backpressure on port 2.
    req = 4'b0010; gnt_t = 4'b1011;
    repeat (2) begin
      @(negedge clk);
      check("t3_gnt", a_gnt, 4'b0);
      check("t3_req_o", a_req_o, 4'b0100);
      check("t3_vld1", a_vld[1], 1'b0);
      model_cycle(); tick();
    end
    gnt_t = 4'hF;
    @(negedge clk);
    check("t3_gnt_go", a_gnt, 4'b0010);
    model_cycle(); tick();
    req = '0;
    @(negedge clk);
    check("t3_vld", a_vld, 4'b0010);
    model_cycle(); tick();

    // Single write: response visibility depends on WriteRespOn and MemLatency.
    req = 4'b0001; add[0] = 2'd0; wen = 4'b0001;
    run(1);
    req = '0; wen = '0;
    @(negedge clk);
    check("t4_a_vld", a_vld, 4'b0001);
    check("t4_b_vld", b_vld, 4'b0);
    check("t4_d_vld_early", d_vld, 4'b0);
    model_cycle(); tick();
    @(negedge clk);
    check("t4_d_vld", d_vld, 4'b0001);
    check("t4_b_vld_late", b_vld, 4'b0);
    model_cycle(); tick();
    @(negedge clk);
    check("t4_d_vld_after", d_vld, 4'b0);
    model_cycle(); tick();

    // Reset while responses are in flight.
    req = 4'hF;
    for (int i = 0; i < 4; i++) add[i] = 2'(i);
    run(1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_a_vld", a_vld, 4'b0);
    check("t5_d_vld", d_vld, 4'b0);
    model_cycle(); tick();
    rst_n = 1'b1; req = '0;
    c_req = 2'b11; c_wen = '0;
    for (int i = 0; i < 2; i++) c_wdata[i] = $urandom;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t5_c_gnt", c_gnt, 2'b11);
      check("t5_c_req_o", c_req_o, (n % 2 == 1) ? 4'b1010 : 4'b0101);
      check("t5_no_resp", a_vld | d_vld, 4'b0);
      model_cycle(); tick();
    end
    c_req = '0; req = 4'hF;
    for (int i = 0; i < 4; i++) add[i] = 2'd1;
    @(negedge clk);
    check("t6_restart_gnt", a_gnt, 4'b0001);
    model_cycle(); tick();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 4; i++) begin
        req[i]   = ($urandom_range(0, 2) != 0);
        add[i]   = 2'($urandom_range(0, 3));
        wen[i]   = $urandom_range(0, 1) == 1;
        wdata[i] = $urandom;
        gnt_t[i] = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 2; i++) begin
        c_req[i]   = $urandom_range(0, 1) == 1;
        c_wen[i]   = $urandom_range(0, 1) == 1;
        c_add[i]   = 2'($urandom_range(0, 3));
        c_wdata[i] = $urandom;
      end
      run(1);
    end
    rst_n = 1'b1; req = '0; c_req = '0;
    run(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clos_router_node.md
Name: clos_router_node

Overview:
- Single switching stage of the Clos TCDM interconnect; instantiated as ingress, middle and egress stages of the three-stage Clos network.
- Combinational request path: NumIn initiators to NumOut targets, one round-robin arbiter per output.
- Response path: returns read data, and a valid pulse, MemLatency cycles after each granted request.
- NodeType selects the routing mode: addressed crossbar, or ingress spreading with no address.

Parameters:
- NumIn, 4, number of initiator ports (power of two, >=1).
- NumOut, 4, number of target ports (power of two, >=1).
- ReqDataWidth, 32, request payload width.
- RespDataWidth, 32, response data width.
- WriteRespOn, 1, 1: vld_o also pulses for writes; 0: reads only.
- MemLatency, 1, cycles from target grant to rdata_i valid (>=1).
- NodeType, 0, 0 = ingress spreading mode (add_i ignored); 1 = addressed routing mode (middle/egress).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NumIn  request per initiator.
- add_i  in  NumIn x AW  target port index; AW = max(1, clog2(NumOut)).
- wen_i  in  NumIn  1 = store, 0 = load.
- wdata_i  in  NumIn x ReqDataWidth  request payload.
- gnt_o  out  NumIn  grant, combinational.
- vld_o  out  NumIn  response valid.
- rdata_o  out  NumIn x RespDataWidth  response data.
- gnt_i  in  NumOut  target grant.
- req_o  out  NumOut  target request.
- wdata_o  out  NumOut x ReqDataWidth  payload forwarded to the target.
- rdata_i  in  NumOut x RespDataWidth  target response data.

Behaviour:
- Destination, NodeType=1: dest[i] = add_i[i].
- Destination, NodeType=0: dest[i] = (i*(NumOut/NumIn) + ptr) mod NumOut.
  - ptr is a clog2(NumOut)-bit counter, reset 0, incremented every cycle, wraps naturally.
  - Requires NumOut >= NumIn, so inputs never collide within one cycle.
  - A blocked request retries on a different output next cycle.
- Per output j:
  - Round-robin arbiter over inputs i with req_i[i] && dest[i]==j.
  - req_o[j] = OR of those requests.
  - wdata_o[j] = wdata_i[winner]; wdata_o = 0 when no request.
- gnt_o[i] = req_i[i] && i is the winner of dest[i] && gnt_i[dest[i]]. Fully combinational; no registers on the forward path.
- Arbiter pointer: reset to 0. Advances to winner+1 (mod NumIn) only on a handshake (req_o[j] && gnt_i[j]); otherwise holds.
- Response tracking, per input: MemLatency-deep shift register of {valid, port index, wen}, loaded each cycle with {gnt_o[i], dest[i], wen_i[i]}.
- At the end of the shift register:
  - rdata_o[i] = rdata_i[stored port].
  - vld_o[i] = stored valid && (WriteRespOn || !stored wen).
  - When not valid, rdata_o[i] still shows the selected port's data; no zeroing required.
- Back-to-back grants on consecutive cycles are pipelined; one response per cycle per input.
- Reset, asynchronous:
  - All shift stages cleared, so vld_o = 0 from reset assertion.
  - Arbiter pointers = 0; ptr = 0.
  - Transactions in flight are dropped.
  - Combinational outputs follow their inputs immediately.
- NumOut=1: add_i is 1 bit and ignored; dest = 0.
- NumIn=1: the arbiter degenerates to pass-through.

Test Plan:
- NodeType=1, NumIn=NumOut=4, all gnt_i=1:
  - Stimulus: req_i=4'b1111, add_i={3,2,1,0}.
  - Required: gnt_o=1111; req_o=1111; wdata_o[k]=wdata_i[k].
  - After MemLatency=1 cycle: vld_o=1111 (wen=0); rdata_o[i]=rdata_i[add_i[i]].
- Contention:
  - Stimulus: inputs 0,1,2 all target port 2 for 3 cycles, gnt_i=1.
  - Required: grants rotate 0,1,2, one per cycle; req_o[2] stays 1; other req_o are 0.
- Backpressure:
  - Stimulus: gnt_i[2]=0 while input 1 requests port 2.
  - Required: req_o[2]=1, gnt_o[1]=0, arbiter pointer unchanged, vld_o stays 0.
  - Then gnt_i[2]=1: gnt_o[1]=1 and vld_o[1]=1 after MemLatency.
- WriteRespOn:
  - Stimulus: a write (wen=1) with WriteRespOn=0.
  - Required: vld_o stays 0.
  - Same write with WriteRespOn=1 and MemLatency=2: vld_o pulses exactly 2 cycles after the grant.
- NodeType=0, NumIn=2, NumOut=4, gnt_i=1:
  - Stimulus: both inputs request continuously.
  - Required: each input is always granted; outputs used follow {0,2},{1,3},{2,0},{3,1},...
  - Every rdata_o comes from the recorded port.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 one cycle after grants.
  - Required: vld_o=0 immediately and no response emerges after release.
  - Arbitration restarts at input 0; ptr restarts at 0.
